// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional error checking is enabled by defining DMEM_RESPONDER_ERR_EN.
package dmem_pkg;

  localparam int WORD_W      = 32;
  localparam int DEPTH_DEF   = 64;
  localparam int LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-strobed synchronous write, asynchronous read,
// and a full clear on asynchronous reset.
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed LATENCY from accept to response.
// Define DMEM_RESPONDER_ERR_EN to flag misaligned or out-of-range requests with rsp_err.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output state_t            dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a request transfers on an edge with req_valid && req_ready, a
  // response on an edge with rsp_valid && rsp_ready; the payload is held
  // stable while valid is high and the partner is not ready.
  state_t state, state_nxt;
  logic [3:0]        cnt;
  logic              lat_we;
  logic              lat_err;
  logic [AW-1:0]     lat_idx;
  logic [WORD_W-1:0] lat_wdata;
  logic [3:0]        lat_wstrb;
  logic              accept;
  logic              commit;
  logic              req_err;
  logic              array_we;
  logic [WORD_W-1:0] rd_data;
  logic              unused_addr;

  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (state == BUSY) && (cnt == 4'd0);
  assign array_we  = commit && lat_we && !lat_err;
  assign dbg_state = state;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_RESPONDER_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)               state_nxt = BUSY;
      BUSY: if (cnt == 4'd0)          state_nxt = RESP;
      RESP: if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Request fields are captured on accept so the core may change them freely afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_wstrb <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= 4'(LATENCY - 1);
        lat_we    <= req_we;
        lat_err   <= req_err;
        lat_idx   <= req_addr[AW+1:2];
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_rdata <= (lat_we || lat_err) ? '0 : rd_data;
        rsp_err   <= lat_err;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (array_we),
    .wstrb (lat_wstrb),
    .addr  (lat_idx),
    .wdata (lat_wdata),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=64, LATENCY=2); error-path steps build
// only when DMEM_RESPONDER_ERR_EN is defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  state_t      dbg_state;

  int checks;
  int failures;

  dmem_responder #(
    .DEPTH   (64),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response, check latency/data/error, then retire it.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_retired"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;

    // reset state
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // store then load back
    do_req("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    do_req("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // partial-strobe merge
    do_req("st20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    do_req("st20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
    do_req("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    do_req("st28", 1'b1, 32'h28, 32'h1234_5678, 4'hA, 32'h0, 1'b0);
    do_req("ld28", 1'b0, 32'h28, 32'h0, 4'h0, 32'h1200_5600, 1'b0);

    // zero strobe still responds, array unchanged
    do_req("st24z", 1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    do_req("ld24", 1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0);

    // stalled response: outputs stable, new request ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_latency", 32'(n), 32'd2);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h44;
    req_wdata = 32'h5555_5555;
    req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    do_req("ld44", 1'b0, 32'h44, 32'h0, 4'h0, 32'h0, 1'b0);

`ifdef DMEM_RESPONDER_ERR_EN
    do_req("st00", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
    do_req("ld102_err", 1'b0, 32'h102, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req("st100_err", 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);
    do_req("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
`else
    do_req("st100_wrap", 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    do_req("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    do_req("ld103", 1'b0, 32'h103, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
`endif

    // reset during BUSY of a store discards it
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hA5A5_A5A5;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("busy_state", 32'(dbg_state), 32'(BUSY));
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel_req_ready", 32'(req_ready), 32'd1);
    check("mid_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    do_req("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    do_req("ld10_cleared", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
